// File: rtl/cpu_pkg.sv
// Shared encodings for the MIPS-subset pipeline: opcodes, functs, ALU ops and
// the decoded control bundle carried down the pipe.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLT = 4'd4,
    ALU_LUI = 4'd5
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    alu_src_imm;
    logic    reg_we;
    logic    mem_rd;
    logic    mem_wr;
    logic    branch;
    logic    illegal;
  } ctrl_t;

endpackage

// File: rtl/id_decoder.sv
// Purely combinational instruction decoder: instruction word to control
// bundle, destination register, extended immediate and rt-usage flag.
module id_decoder
  import cpu_pkg::*;
#(
  parameter logic [31:0] NOP_INSN = 32'h0000_0000
) (
  input  logic [31:0] insn_i,
  output ctrl_t       ctrl_o,
  output logic [4:0]  dest_o,
  output logic [31:0] imm_o,
  output logic        uses_rt_o
);

  logic [5:0]  op, funct;
  logic [15:0] imm16;

  assign op    = insn_i[31:26];
  assign funct = insn_i[5:0];
  assign imm16 = insn_i[15:0];

  always_comb begin
    ctrl_o    = '0;
    dest_o    = insn_i[20:16];
    imm_o     = {{16{imm16[15]}}, imm16};
    uses_rt_o = 1'b0;
    case (op)
      OP_RTYPE: begin
        dest_o        = insn_i[15:11];
        uses_rt_o     = 1'b1;
        ctrl_o.reg_we = 1'b1;
        case (funct)
          FN_ADD:  ctrl_o.alu_op = ALU_ADD;
          FN_SUB:  ctrl_o.alu_op = ALU_SUB;
          FN_AND:  ctrl_o.alu_op = ALU_AND;
          FN_OR:   ctrl_o.alu_op = ALU_OR;
          FN_SLT:  ctrl_o.alu_op = ALU_SLT;
          default: ctrl_o.illegal = 1'b1;
        endcase
      end
      OP_ADDI: begin
        ctrl_o.alu_op = ALU_ADD; ctrl_o.alu_src_imm = 1'b1; ctrl_o.reg_we = 1'b1;
      end
      OP_ANDI: begin
        imm_o         = {16'h0, imm16};
        ctrl_o.alu_op = ALU_AND; ctrl_o.alu_src_imm = 1'b1; ctrl_o.reg_we = 1'b1;
      end
      OP_ORI: begin
        imm_o         = {16'h0, imm16};
        ctrl_o.alu_op = ALU_OR; ctrl_o.alu_src_imm = 1'b1; ctrl_o.reg_we = 1'b1;
      end
      OP_LUI: begin
        imm_o         = {imm16, 16'h0};
        ctrl_o.alu_op = ALU_LUI; ctrl_o.alu_src_imm = 1'b1; ctrl_o.reg_we = 1'b1;
      end
      OP_LW: begin
        ctrl_o.alu_op = ALU_ADD; ctrl_o.alu_src_imm = 1'b1;
        ctrl_o.reg_we = 1'b1;    ctrl_o.mem_rd      = 1'b1;
      end
      OP_SW: begin
        uses_rt_o     = 1'b1;
        ctrl_o.alu_op = ALU_ADD; ctrl_o.alu_src_imm = 1'b1; ctrl_o.mem_wr = 1'b1;
      end
      OP_BEQ: begin
        uses_rt_o     = 1'b1;
        ctrl_o.alu_op = ALU_SUB; ctrl_o.branch = 1'b1;
      end
      default: ctrl_o.illegal = 1'b1;
    endcase

    // An illegal instruction must not produce any architectural side effect.
    if (ctrl_o.illegal) begin
      ctrl_o         = '0;
      ctrl_o.illegal = 1'b1;
    end
    if (dest_o == 5'd0) ctrl_o.reg_we = 1'b0;

    // The bubble encoding overlaps an R-type with funct 0; treat it as a no-op.
    if (insn_i == NOP_INSN) begin
      ctrl_o    = '0;
      dest_o    = 5'd0;
      imm_o     = '0;
      uses_rt_o = 1'b0;
    end
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage: register-file addressing, writeback bypass, load-use hazard
// detection and the ID/EX pipeline register with valid/ready on both sides.
module id_stage
  import cpu_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [31:0] NOP_INSN = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_insn,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic [4:0]      rf_rd0_addr,
  output logic [4:0]      rf_rd1_addr,
  input  logic [XLEN-1:0] rf_rd0_data,
  input  logic [XLEN-1:0] rf_rd1_data,
  input  logic            wb_wr_en,
  input  logic [4:0]      wb_wr_addr,
  input  logic [XLEN-1:0] wb_wr_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_rs_val,
  output logic [XLEN-1:0] out_rt_val,
  output logic [31:0]     out_imm,
  output logic [4:0]      out_dest,
  output logic [3:0]      out_alu_op,
  output logic            out_alu_src_imm,
  output logic            out_reg_we,
  output logic            out_mem_rd,
  output logic            out_mem_wr,
  output logic            out_branch,
  output logic            out_illegal
);

  logic [4:0]      rs, rt;
  ctrl_t           ctrl_d, ctrl_q;
  logic [4:0]      dest_d, dest_q;
  logic [31:0]     imm_d, imm_q;
  logic            uses_rt;
  logic [XLEN-1:0] rs_val_d, rt_val_d, rs_val_q, rt_val_q, pc_q;
  logic            valid_q;
  logic            hazard, advance, load;

  assign rs          = in_insn[25:21];
  assign rt          = in_insn[20:16];
  assign rf_rd0_addr = rs;
  assign rf_rd1_addr = rt;

  id_decoder #(.NOP_INSN(NOP_INSN)) u_dec (
    .insn_i    (in_insn),
    .ctrl_o    (ctrl_d),
    .dest_o    (dest_d),
    .imm_o     (imm_d),
    .uses_rt_o (uses_rt)
  );

  // The register file writes at the same edge we sample, so forward WB data.
  always_comb begin
    rs_val_d = rf_rd0_data;
    rt_val_d = rf_rd1_data;
    if (wb_wr_en && wb_wr_addr == rs) rs_val_d = wb_wr_data;
    if (wb_wr_en && wb_wr_addr == rt) rt_val_d = wb_wr_data;
    if (rs == 5'd0) rs_val_d = '0;
    if (rt == 5'd0) rt_val_d = '0;
  end

  assign hazard = valid_q && ctrl_q.mem_rd && dest_q != 5'd0 &&
                  (dest_q == rs || (uses_rt && dest_q == rt));
  assign advance  = !valid_q || out_ready;
  assign in_ready = advance && !hazard && !flush;
  assign load     = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      rs_val_q <= '0;
      rt_val_q <= '0;
      imm_q    <= '0;
      dest_q   <= '0;
      ctrl_q   <= '0;
    end else if (advance || flush) begin
      valid_q  <= load;
      pc_q     <= load ? in_pc    : '0;
      rs_val_q <= load ? rs_val_d : '0;
      rt_val_q <= load ? rt_val_d : '0;
      imm_q    <= load ? imm_d    : '0;
      dest_q   <= load ? dest_d   : '0;
      ctrl_q   <= load ? ctrl_d   : '0;
    end
  end

  assign out_valid       = valid_q;
  assign out_pc          = pc_q;
  assign out_rs_val      = rs_val_q;
  assign out_rt_val      = rt_val_q;
  assign out_imm         = imm_q;
  assign out_dest        = dest_q;
  assign out_alu_op      = ctrl_q.alu_op;
  assign out_alu_src_imm = ctrl_q.alu_src_imm;
  assign out_reg_we      = ctrl_q.reg_we;
  assign out_mem_rd      = ctrl_q.mem_rd;
  assign out_mem_wr      = ctrl_q.mem_wr;
  assign out_branch      = ctrl_q.branch;
  assign out_illegal     = ctrl_q.illegal;

endmodule
